count_seq_ctrl: RTL and testbench

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

---
 rtl/count_seq_pkg.sv | 15 +
 rtl/count_seq_wdog.sv | 38 +++
 rtl/count_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_count_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the lap-counting sequencer.
package count_seq_pkg;

    localparam int LAP_W_DEF  = 4;
    localparam int WDOG_W_DEF = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSED,
        S_FIN
    } state_e;

endpackage

// File: rtl/count_seq_wdog.sv
// Watchdog for count_seq_ctrl: counts enabled cycles between counted laps and
// flags the cycle on which the count would reach its all-ones terminal value.
module count_seq_wdog #(
    parameter int WDOG_W = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam logic [WDOG_W-1:0] PRE_MAX = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    // Expiry is flagged on the edge that takes the count to all-ones, so the
    // controller reacts on the same edge rather than one cycle late.
    assign expired_o = count_en_i && !clear_i && (cnt_q == PRE_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Lap-counting sequencer driving an external counter's enable and clear.
// Optional watchdog (sticky ERR) is built only when COUNT_SEQ_WDOG_EN is defined.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int LAP_W  = LAP_W_DEF,
    parameter int WDOG_W = WDOG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic [LAP_W-1:0] LAPS,
    input  logic             PAUSE,
    input  logic             ABORT,
    input  logic             MAX,
    output logic             EN,
    output logic             CLR,
    output logic             BUSY,
    output logic             DONE,
    output logic [LAP_W-1:0] LAP_CNT,
    output logic             ERR
);

    state_e            state_q, state_d;
    logic [LAP_W-1:0]  laps_q, laps_d;
    logic [LAP_W-1:0]  lap_cnt_q, lap_cnt_d;
    logic [LAP_W-1:0]  lapNext;
    logic              lapHit;
    logic              wdogExpired;

    assign EN      = (state_q == S_RUN) && !PAUSE;
    assign CLR     = (state_q == S_CLEAR);
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = (state_q == S_FIN) && !ABORT;
    assign LAP_CNT = lap_cnt_q;

    // A lap only counts when the counter was actually enabled; ABORT wins over it.
    assign lapHit  = EN && MAX && !ABORT;
    assign lapNext = lap_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        laps_d    = laps_q;
        lap_cnt_d = lap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    laps_d    = LAPS;
                    lap_cnt_d = '0;
                    state_d   = (LAPS != '0) ? S_CLEAR : S_FIN;
                end
            end
            S_CLEAR: begin
                state_d = ABORT ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (ABORT || wdogExpired) begin
                    state_d = S_IDLE;
                end else if (lapHit) begin
                    lap_cnt_d = lapNext;
                    if (lapNext == laps_q) begin
                        state_d = S_FIN;
                    end
                end else if (PAUSE) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (!PAUSE) begin
                    state_d = S_RUN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            laps_q    <= '0;
            lap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            laps_q    <= laps_d;
            lap_cnt_q <= lap_cnt_d;
        end
    end

`ifdef COUNT_SEQ_WDOG_EN
    logic err_q, err_d;
    logic wdogClear;

    // Restart the watchdog outside an active run and on every counted lap.
    assign wdogClear = ((state_q != S_RUN) && (state_q != S_PAUSED)) || lapHit;

    count_seq_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (wdogClear),
        .count_en_i (EN),
        .expired_o  (wdogExpired)
    );

    always_comb begin
        err_d = err_q;
        if ((state_q == S_IDLE) && START) begin
            err_d = 1'b0;
        end else if (wdogExpired && !ABORT) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    logic unusedWdogW;

    assign unusedWdogW = |WDOG_W;
    assign wdogExpired = 1'b0;
    assign ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed self-checking bench for count_seq_ctrl; the watchdog scenario runs
// only when COUNT_SEQ_WDOG_EN is defined for the build.
module tb_count_seq_ctrl;

    localparam int LAP_W  = 4;
    localparam int WDOG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             START;
    logic [LAP_W-1:0] LAPS;
    logic             PAUSE;
    logic             ABORT;
    logic             MAX;
    logic             EN;
    logic             CLR;
    logic             BUSY;
    logic             DONE;
    logic [LAP_W-1:0] LAP_CNT;
    logic             ERR;

    int checks;
    int errors;

    count_seq_ctrl #(
        .LAP_W  (LAP_W),
        .WDOG_W (WDOG_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .START   (START),
        .LAPS    (LAPS),
        .PAUSE   (PAUSE),
        .ABORT   (ABORT),
        .MAX     (MAX),
        .EN      (EN),
        .CLR     (CLR),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .LAP_CNT (LAP_CNT),
        .ERR     (ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One call = one clock cycle: inputs change mid-low-phase, outputs then settle.
    task automatic applyStimulus(input logic s, input logic [LAP_W-1:0] l,
                                 input logic p, input logic a, input logic m);
        @(negedge clk);
        START = s;
        LAPS  = l;
        PAUSE = p;
        ABORT = a;
        MAX   = m;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_EN"},      8'(EN),      8'h0);
        checkOutput({tag, "_CLR"},     8'(CLR),     8'h0);
        checkOutput({tag, "_BUSY"},    8'(BUSY),    8'h0);
        checkOutput({tag, "_DONE"},    8'(DONE),    8'h0);
        checkOutput({tag, "_LAP_CNT"}, 8'(LAP_CNT), 8'h0);
        checkOutput({tag, "_ERR"},     8'(ERR),     8'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        START  = 1'b0;
        LAPS   = '0;
        PAUSE  = 1'b0;
        ABORT  = 1'b0;
        MAX    = 1'b0;

        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Three laps, MAX every fifth enabled cycle.
        $display("[TB] three-lap run");
        applyStimulus(1, 4'd3, 0, 0, 0);
        checkOutput("l3_idle_busy", 8'(BUSY), 8'h0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("l3_clr", 8'(CLR), 8'h1);
        checkOutput("l3_clr_en", 8'(EN), 8'h0);
        checkOutput("l3_clr_busy", 8'(BUSY), 8'h1);
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                applyStimulus(0, 4'd0, 0, 0, (i == 4));
                checkOutput("l3_run_en", 8'(EN), 8'h1);
                checkOutput("l3_run_clr", 8'(CLR), 8'h0);
                checkOutput("l3_run_done", 8'(DONE), 8'h0);
                checkOutput("l3_run_lap", 8'(LAP_CNT), 8'(k - 1));
            end
        end
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("l3_fin_done", 8'(DONE), 8'h1);
        checkOutput("l3_fin_lap", 8'(LAP_CNT), 8'h3);
        checkOutput("l3_fin_en", 8'(EN), 8'h0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("l3_end_done", 8'(DONE), 8'h0);
        checkOutput("l3_end_busy", 8'(BUSY), 8'h0);
        checkOutput("l3_end_lap", 8'(LAP_CNT), 8'h3);

        // Zero laps: straight to FIN with no clear or enable.
        $display("[TB] zero-lap run");
        applyStimulus(1, 4'd0, 0, 0, 0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("l0_done", 8'(DONE), 8'h1);
        checkOutput("l0_clr", 8'(CLR), 8'h0);
        checkOutput("l0_en", 8'(EN), 8'h0);
        checkOutput("l0_lap", 8'(LAP_CNT), 8'h0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("l0_end_done", 8'(DONE), 8'h0);
        checkOutput("l0_end_busy", 8'(BUSY), 8'h0);

        // Pause held four cycles with MAX high throughout.
        $display("[TB] pause run");
        applyStimulus(1, 4'd2, 0, 0, 0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("p_clr", 8'(CLR), 8'h1);
        applyStimulus(0, 4'd0, 0, 0, 1);
        checkOutput("p_run_en", 8'(EN), 8'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 4'd0, 1, 0, 1);
            checkOutput("p_pause_en", 8'(EN), 8'h0);
            checkOutput("p_pause_lap", 8'(LAP_CNT), 8'h1);
            checkOutput("p_pause_busy", 8'(BUSY), 8'h1);
        end
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("p_resume_en0", 8'(EN), 8'h0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("p_resume_en1", 8'(EN), 8'h1);
        checkOutput("p_resume_lap", 8'(LAP_CNT), 8'h1);
        applyStimulus(0, 4'd0, 0, 0, 1);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("p_fin_done", 8'(DONE), 8'h1);
        checkOutput("p_fin_lap", 8'(LAP_CNT), 8'h2);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("p_end_busy", 8'(BUSY), 8'h0);

        // ABORT coinciding with the final MAX, plus a START during the run.
        $display("[TB] abort run");
        applyStimulus(1, 4'd2, 0, 0, 0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("a_clr", 8'(CLR), 8'h1);
        applyStimulus(1, 4'd1, 0, 0, 1);
        checkOutput("a_run_en", 8'(EN), 8'h1);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("a_restart_clr", 8'(CLR), 8'h0);
        checkOutput("a_restart_lap", 8'(LAP_CNT), 8'h1);
        checkOutput("a_restart_busy", 8'(BUSY), 8'h1);
        applyStimulus(0, 4'd0, 0, 1, 1);
        checkOutput("a_abort_done", 8'(DONE), 8'h0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("a_idle_busy", 8'(BUSY), 8'h0);
        checkOutput("a_idle_done", 8'(DONE), 8'h0);
        checkOutput("a_idle_lap", 8'(LAP_CNT), 8'h1);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("a_idle2_done", 8'(DONE), 8'h0);

        // Asynchronous reset in the middle of a run.
        $display("[TB] async reset mid-run");
        applyStimulus(1, 4'd3, 0, 0, 0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        applyStimulus(0, 4'd0, 0, 0, 1);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("r_pre_en", 8'(EN), 8'h1);
        checkOutput("r_pre_lap", 8'(LAP_CNT), 8'h1);
        rst_n = 1'b0;
        #1;
        checkAllZero("r_async");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("r_after_busy", 8'(BUSY), 8'h0);
        checkOutput("r_after_done", 8'(DONE), 8'h0);

`ifdef COUNT_SEQ_WDOG_EN
        // Fifteen enabled cycles without a lap trip the 4-bit watchdog.
        $display("[TB] watchdog run");
        applyStimulus(1, 4'd1, 0, 0, 0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(0, 4'd0, 0, 0, 0);
            checkOutput("w_run_en", 8'(EN), 8'h1);
            checkOutput("w_run_err", 8'(ERR), 8'h0);
        end
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("w_err", 8'(ERR), 8'h1);
        checkOutput("w_busy", 8'(BUSY), 8'h0);
        checkOutput("w_done", 8'(DONE), 8'h0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("w_err_sticky", 8'(ERR), 8'h1);
        applyStimulus(1, 4'd1, 0, 0, 0);
        applyStimulus(0, 4'd0, 0, 0, 0);
        checkOutput("w_err_cleared", 8'(ERR), 8'h0);
        checkOutput("w_restart_clr", 8'(CLR), 8'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
